usb_tx_timer: RTL

- Bit-timing and bit-count generator for the USB 1.0 transmit path; the counterpart of the receive-side timer.
- Divides the system clock into bit periods and tells the TX shift register when to drive the next NRZI bit and when a byte has been fully sent.
- Supports bit-stuff insertion: a stuff period is an extra bit period that does not advance the data-bit count.
- Sits between the TX control FSM (drives timer_en/timer_clr/stuff_req) and the TX shift register/NRZI encoder (consumes the strobes).

---
 rtl/usb_tx_timer.sv | 80 ++++++++
 1 files changed

// File: rtl/usb_tx_timer.sv
// rtl/usb_tx_timer.sv - USB 1.0 transmit bit-timing and bit-count generator with stuff-bit support
module usb_tx_timer #(
  parameter int CLKS_PER_BIT  = 8,
  parameter int BITS_PER_BYTE = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       timer_en,
  input  logic       timer_clr,
  input  logic       stuff_req,
  output logic       bit_strobe,
  output logic       bit_done,
  output logic       shift_strobe,
  output logic       byte_done,
  output logic       stuff_active,
  output logic [3:0] pd_count,
  output logic [3:0] bit_count
);

  typedef enum logic {
    S_DATA  = 1'b0,
    S_STUFF = 1'b1
  } state_e;

  localparam logic [3:0] PD_LAST  = 4'(CLKS_PER_BIT - 1);
  localparam logic [3:0] BIT_LAST = 4'(BITS_PER_BYTE - 1);

  state_e     state_q, state_d;
  logic [3:0] pd_count_q, pd_count_d;
  logic [3:0] bit_count_q, bit_count_d;

  // State register: period counter, data-bit counter and DATA/STUFF state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_DATA;
      pd_count_q  <= 4'd0;
      bit_count_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      pd_count_q  <= pd_count_d;
      bit_count_q <= bit_count_d;
    end
  end

  // Strobe decode and next-state: clear beats enable; counters only move while enabled
  always_comb begin
    state_d      = state_q;
    pd_count_d   = pd_count_q;
    bit_count_d  = bit_count_q;

    bit_strobe   = timer_en && (pd_count_q == 4'd0);
    bit_done     = timer_en && (pd_count_q == PD_LAST);
    shift_strobe = bit_done && (state_q == S_DATA);
    byte_done    = shift_strobe && (bit_count_q == BIT_LAST);
    stuff_active = (state_q == S_STUFF);

    if (timer_clr) begin
      state_d     = S_DATA;
      pd_count_d  = 4'd0;
      bit_count_d = 4'd0;
    end else if (timer_en) begin
      pd_count_d = bit_done ? 4'd0 : pd_count_q + 4'd1;
      if (bit_done) begin
        case (state_q)
          S_DATA: begin
            bit_count_d = (bit_count_q == BIT_LAST) ? 4'd0 : bit_count_q + 4'd1;
            state_d     = stuff_req ? S_STUFF : S_DATA;
          end
          // A stuffed 0 can never itself require stuffing, so stuff_req is ignored here
          S_STUFF: state_d = S_DATA;
          default: state_d = S_DATA;
        endcase
      end
    end
  end

  assign pd_count  = pd_count_q;
  assign bit_count = bit_count_q;

endmodule
